// File: rtl/ps2_pkt_pkg.sv
// ps2_pkt_pkg: shared state type and default parameters for the PS/2 packet framer
package ps2_pkt_pkg;

    typedef enum logic {HUNT, COLLECT} framer_state_t;

    localparam int PKT_BYTES_DEF = 3;
    localparam int SYNC_BIT_DEF  = 3;
    localparam int TIMEOUT_DEF   = 1000;
    localparam int DROP_CNT_W    = 16;

endpackage

// File: rtl/ps2_gap_timer.sv
// ps2_gap_timer: counts consecutive idle cycles and pulses expire on the TIMEOUT-th one
module ps2_gap_timer
    import ps2_pkt_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    // TIMEOUT=0 still keeps a 1-bit counter, pinned at zero, so the ports stay live
    localparam int W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expire = (TIMEOUT != 0) && run && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn || clear || expire || TIMEOUT == 0)
            cnt <= '0;
        else if (run)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ps2_packet_framer.sv
// ps2_packet_framer: aligns strobed bytes into PKT_BYTES packets using a sync bit in byte 0
module ps2_packet_framer
    import ps2_pkt_pkg::*;
#(
    parameter int PKT_BYTES = PKT_BYTES_DEF,
    parameter int SYNC_BIT  = SYNC_BIT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    output logic                   err_timeout,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int W  = 8 * PKT_BYTES;
    localparam int IW = $clog2(PKT_BYTES);

    framer_state_t  state, state_n;
    logic [IW-1:0]  idx;
    logic [W-1:0]   asm_q;
    logic [W-1:0]   shifted;
    logic           start, drop, take, last, expire;

    // Exactly PKT_BYTES shifts happen per packet, so stale bytes are always pushed out
    assign shifted = {asm_q[W-9:0], din};

    always_comb begin
        start   = (state == HUNT) && din_valid && din[SYNC_BIT];
        drop    = (state == HUNT) && din_valid && !din[SYNC_BIT];
        take    = (state == COLLECT) && din_valid;
        last    = take && (idx == IW'(PKT_BYTES - 1));
        state_n = start ? COLLECT : (last || expire) ? HUNT : state;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= HUNT;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx         <= '0;
            asm_q       <= '0;
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            idx         <= start ? IW'(1) : (last || expire) ? '0 : take ? idx + IW'(1) : idx;
            asm_q       <= (start || take) ? shifted : asm_q;
            pkt_data    <= last ? shifted : pkt_data;
            pkt_valid   <= last;
            err_timeout <= expire;
            drop_cnt    <= (drop && drop_cnt != '1) ? drop_cnt + DROP_CNT_W'(1) : drop_cnt;
        end
    end

    ps2_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
        .clk    (clk),
        .resetn (resetn),
        .run    ((state == COLLECT) && !din_valid),
        .clear  ((state == HUNT) || take),
        .expire (expire)
    );

endmodule

// File: tb/tb_ps2_packet_framer.sv
// tb_ps2_packet_framer: three framer configurations driven side by side against a queue-based model
module tb_ps2_packet_framer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  dn [3];
    logic        dv [3];
    logic [23:0] pd0, pd2;
    logic [31:0] pd1;
    logic        pv [3];
    logic        et [3];
    logic [15:0] dc [3];

    int passed = 0;
    int total  = 0;

    int PB [3] = '{3, 4, 3};
    int SB [3] = '{3, 7, 3};
    int TO [3] = '{1000, 5, 0};

    byte unsigned q [3][$];
    int           idle [3];
    logic [63:0]  epd [3];
    logic         epv [3];
    logic         eet [3];
    int           edrop [3];

    always #5 clk = ~clk;

    ps2_packet_framer u0 (.clk(clk), .resetn(resetn), .din(dn[0]), .din_valid(dv[0]),
        .pkt_data(pd0), .pkt_valid(pv[0]), .err_timeout(et[0]), .drop_cnt(dc[0]));
    ps2_packet_framer #(.PKT_BYTES(4), .SYNC_BIT(7), .TIMEOUT(5)) u1 (.clk(clk), .resetn(resetn),
        .din(dn[1]), .din_valid(dv[1]), .pkt_data(pd1), .pkt_valid(pv[1]), .err_timeout(et[1]),
        .drop_cnt(dc[1]));
    ps2_packet_framer #(.TIMEOUT(0)) u2 (.clk(clk), .resetn(resetn), .din(dn[2]), .din_valid(dv[2]),
        .pkt_data(pd2), .pkt_valid(pv[2]), .err_timeout(et[2]), .drop_cnt(dc[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model(input int k, input logic rn, input logic v, input logic [7:0] b);
        logic [63:0] p;
        epv[k] = 1'b0;
        eet[k] = 1'b0;
        if (!rn) begin
            q[k].delete();
            idle[k] = 0;
            epd[k] = '0;
            edrop[k] = 0;
        end else if (q[k].size() == 0) begin
            if (v && b[SB[k]]) q[k].push_back(b);
            else if (v && edrop[k] < 65535) edrop[k]++;
        end else if (v) begin
            q[k].push_back(b);
            idle[k] = 0;
            if (q[k].size() == PB[k]) begin
                p = '0;
                foreach (q[k][i]) p = (p << 8) | 64'(q[k][i]);
                epd[k] = p;
                epv[k] = 1'b1;
                q[k].delete();
            end
        end else begin
            idle[k]++;
            if (TO[k] != 0 && idle[k] == TO[k]) begin
                eet[k] = 1'b1;
                q[k].delete();
                idle[k] = 0;
            end
        end
    endtask

    task automatic tick();
        logic [63:0] obs;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model(k, resetn, dv[k], dn[k]);
        #1;
        for (int k = 0; k < 3; k++) begin
            obs = (k == 0) ? 64'(pd0) : (k == 1) ? 64'(pd1) : 64'(pd2);
            chk($sformatf("pkt_data%0d", k), obs, epd[k]);
            chk($sformatf("pkt_valid%0d", k), 64'(pv[k]), 64'(epv[k]));
            chk($sformatf("err_timeout%0d", k), 64'(et[k]), 64'(eet[k]));
            chk($sformatf("drop_cnt%0d", k), 64'(dc[k]), 64'(edrop[k]));
        end
        for (int k = 0; k < 3; k++) dv[k] = 1'b0;
    endtask

    task automatic feed(input int k, input logic [7:0] b);
        dv[k] = 1'b1;
        dn[k] = b;
        tick();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0;
            dn[k] = 8'hFF;
            idle[k] = 0;
            epd[k] = '0;
            epv[k] = 1'b0;
            eet[k] = 1'b0;
            edrop[k] = 0;
        end
        resetn = 1'b0;
        gap(2);
        chk("reset_pkt_data", 64'(pd0), 64'h0);
        resetn = 1'b1;

        feed(0, 8'h08); feed(0, 8'h11); feed(0, 8'h22);
        chk("t1_valid", 64'(pv[0]), 64'h1);
        chk("t1_data", 64'(pd0), 64'h081122);
        chk("t1_drop", 64'(dc[0]), 64'h0);
        gap(1);
        chk("t1_pulse_one_cycle", 64'(pv[0]), 64'h0);

        feed(0, 8'h00); feed(0, 8'h07); feed(0, 8'h08); feed(0, 8'hAA); feed(0, 8'hBB);
        chk("t2_data", 64'(pd0), 64'h08AABB);
        chk("t2_drop", 64'(dc[0]), 64'h2);
        feed(0, 8'h0F);
        chk("t2_hold", 64'(pd0), 64'h08AABB);
        feed(0, 8'h01); feed(0, 8'h02);
        chk("t2_b2b_valid", 64'(pv[0]), 64'h1);
        chk("t2_b2b_data", 64'(pd0), 64'h0F0102);

        feed(1, 8'h81); feed(1, 8'h0A); feed(1, 8'h0B); feed(1, 8'h0C);
        chk("t3_first", 64'(pd1), 64'h810A0B0C);
        feed(1, 8'h80); feed(1, 8'h01);
        gap(4);
        chk("t3_no_early_abort", 64'(et[1]), 64'h0);
        gap(1);
        chk("t3_abort", 64'(et[1]), 64'h1);
        chk("t3_retain", 64'(pd1), 64'h810A0B0C);
        feed(1, 8'h80); feed(1, 8'h01);
        gap(4);
        feed(1, 8'h02); feed(1, 8'h03);
        chk("t3_data", 64'(pd1), 64'h80010203);

        for (int i = 0; i < 2000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 3; k++) begin
                dv[k] = ($urandom_range(0, 9) < 6);
                dn[k] = 8'($urandom);
            end
            tick();
        end
        resetn = 1'b1;
        gap(6);

        feed(0, 8'h08); feed(0, 8'h11);
        resetn = 1'b0;
        dv[0] = 1'b1;
        dn[0] = 8'h22;
        tick();
        resetn = 1'b1;
        chk("rst_data", 64'(pd0), 64'h0);
        chk("rst_drop", 64'(dc[0]), 64'h0);
        feed(0, 8'h01); feed(0, 8'h02);
        chk("rst_drop2", 64'(dc[0]), 64'h2);
        feed(0, 8'h08); feed(0, 8'h33); feed(0, 8'h44);
        chk("rst_next", 64'(pd0), 64'h083344);

        feed(2, 8'h08);
        for (int i = 0; i < 70000; i++) begin
            dv[0] = 1'b1;
            dn[0] = 8'($urandom) & 8'hF7;
            tick();
        end
        chk("sat_drop", 64'(dc[0]), 64'hFFFF);
        chk("to0_no_abort", 64'(et[2]), 64'h0);
        feed(2, 8'h01); feed(2, 8'h02);
        chk("to0_data", 64'(pd2), 64'h080102);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_packet_framer.md
# ps2_packet_framer

Parametrised successor to the fixed 3-byte PS/2 mouse framer. Collects a stream of strobed bytes into packets of `PKT_BYTES` bytes, aligned by a sync bit in the first byte. It presents each complete packet on a registered, held-stable bus with a one-cycle valid pulse. It adds a byte-gap timeout with abort/error reporting and a saturating count of discarded bytes. It sits between the PS/2 byte receiver and the packet decoder.

## Interface
- `PKT_BYTES`, default 3: bytes per packet, legal range 2..8.
- `SYNC_BIT`, default 3: bit of the first byte that must be 1 to start a packet, range 0..7.
- `TIMEOUT`, default 1000: consecutive idle cycles inside a packet that abort it; 0 disables the timeout.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `resetn` in 1: synchronous reset, active-low.
- `din` in 8: byte from the receiver.
- `din_valid` in 1: `din` is a new byte this cycle.
- `pkt_data` out 8*PKT_BYTES: last complete packet; first byte is in the MSBs.
- `pkt_valid` out 1: one-cycle pulse when `pkt_data` updates.
- `err_timeout` out 1: one-cycle pulse when a partial packet is aborted.
- `drop_cnt` out 16: saturating count of bytes discarded while hunting.

## Operation
- States are HUNT and COLLECT.
- HUNT:
  - A byte with `din_valid=1` and `din[SYNC_BIT]=1` is stored as byte 0, sets `idx=1` and moves to COLLECT.
  - A byte with the sync bit at 0 is discarded and `drop_cnt` increments, saturating at 0xFFFF.
- COLLECT:
  - Each accepted byte is stored at position `idx`, `idx` increments, and the gap counter clears.
  - When byte `PKT_BYTES-1` is accepted, the whole assembly copies to `pkt_data`, `pkt_valid` is set, and the state returns to HUNT.
  - Bytes in COLLECT are never sync-checked.
- Gap timer:
  - Counts cycles in COLLECT with `din_valid=0` and clears on every accepted byte.
  - On the TIMEOUT-th consecutive idle cycle: state goes to HUNT, `err_timeout` is set, and the partial assembly is discarded. `pkt_data` is unchanged.
  - The counter is wide enough for TIMEOUT (`$clog2(TIMEOUT+1)`). With TIMEOUT=0 the counter is held at 0 and never fires.
- `pkt_data` holds its value until the next complete packet; it is never X and never shows a partial packet.
- `resetn=0` at any time, including mid-packet:
  - State goes to HUNT, `idx=0`, gap counter to 0.
  - `pkt_data`, `pkt_valid`, `err_timeout` and `drop_cnt` all go to 0.
  - The byte presented in the reset cycle is ignored.

## Timing
- All outputs are registered.
- `pkt_valid` is high in the cycle after the edge that accepts the last byte, for exactly one cycle. `pkt_data` is valid from that same cycle.
- Back-to-back packets:
  - A sync byte may arrive in the cycle immediately after the last byte, i.e. while `pkt_valid` is high. It is accepted as byte 0 of the next packet with no bubble.
  - With continuous `din_valid`, one packet completes every `PKT_BYTES` cycles.
- `err_timeout` is high in the cycle after the aborting idle cycle. A sync byte in that same cycle starts a new packet.
- `pkt_valid` and `err_timeout` are never high together.
- `drop_cnt` updates the cycle after the discarded byte.
- `din` is ignored whenever `din_valid=0`.

## Structure
- Package `ps2_pkt_pkg` holds:
  - the `framer_state_t` enum (HUNT, COLLECT);
  - the default parameter constants;
  - the `DROP_CNT_W=16` constant.
- Sub-module `ps2_gap_timer` (params TIMEOUT; ports `clk`, `resetn`, `run`, `clear`, `expire`) holds the idle counter and the TIMEOUT=0 bypass.
- The top level holds the FSM, the assembly shift register, the output register and `drop_cnt`.

## Test plan
- Defaults, continuous valid, bytes 0x08,0x11,0x22 → `pkt_valid` one cycle later, `pkt_data`=0x081122, `drop_cnt`=0.
- Defaults, bytes 0x00,0x07,0x08,0xAA,0xBB → `drop_cnt`=2, then `pkt_data`=0x08AABB; back-to-back packet 0x0F,0x01,0x02 immediately after → second pulse 3 cycles after the first, `pkt_data`=0x0F0102.
- PKT_BYTES=4, SYNC_BIT=7, TIMEOUT=5: 0x80,0x01, then 5 idle cycles → `err_timeout` pulse, `pkt_data` retains the previous value. Repeat with 4 idle cycles then 0x02,0x03 → `pkt_data`=0x80010203.
- TIMEOUT=0: 0x08, 10000 idle cycles, 0x01,0x02 → no `err_timeout`, `pkt_data`=0x080102.
- `resetn=0` for one cycle after byte 2 of a packet → all outputs 0. The next bytes 0x01,0x02 are dropped (`drop_cnt`=2) until the next sync byte.
- Feed 70000 non-sync bytes → `drop_cnt` saturates at 0xFFFF.
